// File: rtl/data_mem_hs_if.sv
// Request/response handshake bundle between the MEM stage and the data memory.
// The master issues requests and consumes responses; the slave is the memory.
interface data_mem_hs_if #(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [DM_ADDRESS-1:0] req_addr;
    logic [DATA_W-1:0]     req_wdata;
    logic [2:0]            req_funct3;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_W-1:0]     rsp_rdata;
    logic                  rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_funct3, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_funct3, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/data_mem_hs.sv
// RV32 data memory: byte-lane RAM behind a single-outstanding valid/ready handshake,
// with load/store lane steering, sign/zero extension and misaligned/illegal detection.
module data_mem_hs #(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32,
    parameter int RD_LAT     = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    data_mem_hs_if.slave  bus
);
    localparam int DEPTH = 2 ** (DM_ADDRESS - 2);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam logic [2:0] CNT_LAST = 3'(RD_LAT - 1);

    generate
        if (DATA_W != 32) begin : g_bad_width
            $error("data_mem_hs: DATA_W must be 32");
        end
        if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_lat
            $error("data_mem_hs: RD_LAT must be 1..4");
        end
    endgenerate

    logic [1:0]            state_q, state_d;
    logic [2:0]            cnt_q, cnt_d;
    logic                  err_q, err_d;
    logic                  we_q, we_d;
    logic [2:0]            f3_q, f3_d;
    logic [1:0]            off_q, off_d;

    logic [1:0]            req_off;
    logic [DM_ADDRESS-3:0] req_idx;
    logic                  accept;
    logic                  illegal;
    logic                  misaligned;
    logic                  req_err;
    logic [3:0]            byte_en;
    logic [31:0]           wr_word;
    logic                  wr_en;
    logic                  rd_en;
    logic [3:0][7:0]       rd_lane;
    logic [31:0]           rd_shift;
    logic [31:0]           load_ext;

    assign req_off = bus.req_addr[1:0];
    assign req_idx = bus.req_addr[DM_ADDRESS-1:2];
    assign accept  = bus.req_valid && (state_q == S_IDLE);

    always_comb begin
        illegal    = 1'b0;
        misaligned = 1'b0;
        byte_en    = 4'b1111;
        wr_word    = bus.req_wdata;
        if (bus.req_we) begin
            illegal = bus.req_funct3[2] || (bus.req_funct3[1:0] == 2'b11);
        end else begin
            illegal = (bus.req_funct3 == 3'b011) || (bus.req_funct3 == 3'b110) ||
                      (bus.req_funct3 == 3'b111);
        end
        misaligned = ((bus.req_funct3[1:0] == 2'b01) && req_off[0]) ||
                     ((bus.req_funct3[1:0] == 2'b10) && (req_off != 2'b00));
        // Store data is replicated across lanes so each lane only needs its enable.
        case (bus.req_funct3[1:0])
            2'b00: begin
                byte_en = 4'b0001 << req_off;
                wr_word = {4{bus.req_wdata[7:0]}};
            end
            2'b01: begin
                byte_en = 4'b0011 << req_off;
                wr_word = {2{bus.req_wdata[15:0]}};
            end
            default: begin
                byte_en = 4'b1111;
                wr_word = bus.req_wdata;
            end
        endcase
    end

    assign req_err = illegal || misaligned;
    // Gating with rst_n keeps a request presented during reset from touching the RAM.
    assign wr_en   = accept && rst_n && bus.req_we && !req_err;
    assign rd_en   = accept && rst_n && !bus.req_we && !req_err;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] mem [DEPTH];
            logic [7:0] rd_byte_q;

            always_ff @(posedge clk) begin
                if (wr_en && byte_en[gi]) begin
                    mem[req_idx] <= wr_word[8*gi +: 8];
                end
                if (rd_en) begin
                    rd_byte_q <= mem[req_idx];
                end
            end

            assign rd_lane[gi] = rd_byte_q;
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        we_d    = we_q;
        f3_d    = f3_q;
        off_d   = off_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    err_d = req_err;
                    we_d  = bus.req_we;
                    f3_d  = bus.req_funct3;
                    off_d = req_off;
                    if (!bus.req_we && !req_err && (RD_LAT > 1)) begin
                        state_d = S_WAIT;
                        cnt_d   = 3'd1;
                    end else begin
                        state_d = S_RESP;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = S_RESP;
                    cnt_d   = 3'd0;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            S_RESP: begin
                if (bus.rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 3'd0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            f3_q    <= 3'd0;
            off_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            we_q    <= we_d;
            f3_q    <= f3_d;
            off_q   <= off_d;
        end
    end

    // The captured word and access fields are held, so the extended result is stable in RESP.
    always_comb begin
        rd_shift = rd_lane >> {off_q, 3'b000};
        case (f3_q)
            3'b000:  load_ext = {{24{rd_shift[7]}}, rd_shift[7:0]};
            3'b100:  load_ext = {24'd0, rd_shift[7:0]};
            3'b001:  load_ext = {{16{rd_shift[15]}}, rd_shift[15:0]};
            3'b101:  load_ext = {16'd0, rd_shift[15:0]};
            default: load_ext = rd_lane;
        endcase
    end

    assign bus.req_ready = (state_q == S_IDLE);
    assign bus.rsp_valid = (state_q == S_RESP);
    assign bus.rsp_err   = (state_q == S_RESP) && err_q;
    assign bus.rsp_rdata = ((state_q == S_RESP) && !we_q && !err_q) ? load_ext : '0;
endmodule

// File: tb/tb_data_mem_hs.sv
// Directed bench for data_mem_hs at RD_LAT=3: stores, extended loads, errors,
// back-pressure and reset during a pending load.
module tb_data_mem_hs;
    localparam int DM_ADDRESS = 9;
    localparam int DATA_W     = 32;
    localparam int RD_LAT     = 3;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    data_mem_hs_if #(.DM_ADDRESS(DM_ADDRESS), .DATA_W(DATA_W)) bus ();

    data_mem_hs #(.DM_ADDRESS(DM_ADDRESS), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issues one request and waits (bounded) for its response; rsp_ready is left to the caller.
    task automatic xact(input logic we, input logic [8:0] addr, input logic [31:0] wdata,
                        input logic [2:0] f3, output logic [31:0] rdata, output logic err,
                        output int lat);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        bus.req_funct3 = f3;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        lat = 1;
        while (!bus.rsp_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        rdata = bus.rsp_rdata;
        err   = bus.rsp_err;
        checks++;
        if (!bus.rsp_valid) begin
            errors++;
            $display("FAIL rsp_timeout: got rsp_valid=%0d required 1 within 20 cycles", bus.rsp_valid);
        end
        $display("xact we=%0d f3=%03b addr=%03h wdata=%08h -> rdata=%08h err=%0d lat=%0d",
                 we, f3, addr, wdata, rdata, err, lat);
    endtask

    task automatic test_reset();
        rst_n          = 1'b0;
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        bus.req_funct3 = 3'b000;
        bus.rsp_ready  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.req_ready !== 1'b1) begin
            errors++; $display("FAIL reset_req_ready: got %0d required 1", bus.req_ready);
        end
        checks++;
        if (bus.rsp_valid !== 1'b0) begin
            errors++; $display("FAIL reset_rsp_valid: got %0d required 0", bus.rsp_valid);
        end
        checks++;
        if (bus.rsp_rdata !== 32'h0) begin
            errors++; $display("FAIL reset_rsp_rdata: got %08h required 00000000", bus.rsp_rdata);
        end
        checks++;
        if (bus.rsp_err !== 1'b0) begin
            errors++; $display("FAIL reset_rsp_err: got %0d required 0", bus.rsp_err);
        end
        @(negedge clk);
        rst_n = 1'b1;
        $display("reset released");
    endtask

    task automatic test_word();
        logic [31:0] rd; logic er; int lat;
        xact(1'b1, 9'h010, 32'hDEADBEEF, 3'b010, rd, er, lat);
        checks++;
        if (rd !== 32'h0 || er !== 1'b0 || lat != 1) begin
            errors++; $display("FAIL sw_rsp: got rdata=%08h err=%0d lat=%0d required 00000000 0 1", rd, er, lat);
        end
        xact(1'b0, 9'h010, 32'h0, 3'b010, rd, er, lat);
        checks++;
        if (rd !== 32'hDEADBEEF) begin
            errors++; $display("FAIL lw_data: got %08h required deadbeef", rd);
        end
        checks++;
        if (er !== 1'b0) begin
            errors++; $display("FAIL lw_err: got %0d required 0", er);
        end
        checks++;
        if (lat != RD_LAT) begin
            errors++; $display("FAIL lw_latency: got %0d required %0d", lat, RD_LAT);
        end
    endtask

    task automatic test_byte_half();
        logic [31:0] rd; logic er; int lat;
        xact(1'b1, 9'h013, 32'h00000080, 3'b000, rd, er, lat);
        checks++;
        if (er !== 1'b0 || lat != 1) begin
            errors++; $display("FAIL sb_rsp: got err=%0d lat=%0d required 0 1", er, lat);
        end
        xact(1'b0, 9'h013, 32'h0, 3'b000, rd, er, lat);
        checks++;
        if (rd !== 32'hFFFFFF80) begin
            errors++; $display("FAIL lb_sign: got %08h required ffffff80", rd);
        end
        xact(1'b0, 9'h013, 32'h0, 3'b100, rd, er, lat);
        checks++;
        if (rd !== 32'h00000080) begin
            errors++; $display("FAIL lbu_zero: got %08h required 00000080", rd);
        end
        xact(1'b0, 9'h012, 32'h0, 3'b001, rd, er, lat);
        checks++;
        if (rd !== 32'hFFFF80AD) begin
            errors++; $display("FAIL lh_sign: got %08h required ffff80ad", rd);
        end
        xact(1'b0, 9'h011, 32'h0, 3'b100, rd, er, lat);
        checks++;
        if (rd !== 32'h000000BE) begin
            errors++; $display("FAIL lbu_lane1: got %08h required 000000be", rd);
        end
    endtask

    task automatic test_half_store();
        logic [31:0] rd; logic er; int lat;
        xact(1'b1, 9'h014, 32'h00000000, 3'b010, rd, er, lat);
        xact(1'b1, 9'h016, 32'hCAFE1234, 3'b001, rd, er, lat);
        checks++;
        if (er !== 1'b0 || rd !== 32'h0) begin
            errors++; $display("FAIL sh_rsp: got rdata=%08h err=%0d required 00000000 0", rd, er);
        end
        xact(1'b0, 9'h014, 32'h0, 3'b010, rd, er, lat);
        checks++;
        if (rd !== 32'h12340000) begin
            errors++; $display("FAIL sh_lw: got %08h required 12340000", rd);
        end
        xact(1'b0, 9'h016, 32'h0, 3'b101, rd, er, lat);
        checks++;
        if (rd !== 32'h00001234) begin
            errors++; $display("FAIL lhu_zero: got %08h required 00001234", rd);
        end
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic er; int lat;
        xact(1'b0, 9'h011, 32'h0, 3'b010, rd, er, lat);
        checks++;
        if (er !== 1'b1 || rd !== 32'h0 || lat != 1) begin
            errors++; $display("FAIL lw_misaligned: got err=%0d rdata=%08h lat=%0d required 1 00000000 1", er, rd, lat);
        end
        xact(1'b1, 9'h013, 32'h0000FFFF, 3'b001, rd, er, lat);
        checks++;
        if (er !== 1'b1 || rd !== 32'h0 || lat != 1) begin
            errors++; $display("FAIL sh_misaligned: got err=%0d rdata=%08h lat=%0d required 1 00000000 1", er, rd, lat);
        end
        xact(1'b0, 9'h010, 32'h0, 3'b011, rd, er, lat);
        checks++;
        if (er !== 1'b1 || rd !== 32'h0 || lat != 1) begin
            errors++; $display("FAIL ld_illegal: got err=%0d rdata=%08h lat=%0d required 1 00000000 1", er, rd, lat);
        end
        xact(1'b1, 9'h010, 32'h11111111, 3'b100, rd, er, lat);
        checks++;
        if (er !== 1'b1 || rd !== 32'h0) begin
            errors++; $display("FAIL st_illegal: got err=%0d rdata=%08h required 1 00000000", er, rd);
        end
        xact(1'b0, 9'h010, 32'h0, 3'b010, rd, er, lat);
        checks++;
        if (rd !== 32'h80ADBEEF || er !== 1'b0) begin
            errors++; $display("FAIL err_no_write: got %08h err=%0d required 80adbeef 0", rd, er);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] rd; logic er; int lat;
        bus.rsp_ready = 1'b0;
        xact(1'b0, 9'h010, 32'h0, 3'b010, rd, er, lat);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 32'h80ADBEEF ||
                bus.rsp_err !== 1'b0 || bus.req_ready !== 1'b0) begin
                errors++;
                $display("FAIL hold_cycle%0d: got valid=%0d rdata=%08h err=%0d req_ready=%0d required 1 80adbeef 0 0",
                         i, bus.rsp_valid, bus.rsp_rdata, bus.rsp_err, bus.req_ready);
            end
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
            errors++; $display("FAIL hold_release: got valid=%0d req_ready=%0d required 0 1", bus.rsp_valid, bus.req_ready);
        end
        $display("backpressure held 5 cycles");
    endtask

    task automatic test_reset_wait();
        logic [31:0] rd; logic er; int lat;
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b0;
        bus.req_addr   = 9'h014;
        bus.req_funct3 = 3'b010;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        checks++;
        if (bus.req_ready !== 1'b0 || bus.rsp_valid !== 1'b0) begin
            errors++; $display("FAIL wait_state: got req_ready=%0d valid=%0d required 0 0", bus.req_ready, bus.rsp_valid);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
            errors++; $display("FAIL reset_in_wait: got valid=%0d req_ready=%0d required 0 1", bus.rsp_valid, bus.req_ready);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        $display("reset during WAIT released");
        xact(1'b0, 9'h014, 32'h0, 3'b010, rd, er, lat);
        checks++;
        if (rd !== 32'h12340000 || lat != RD_LAT) begin
            errors++; $display("FAIL post_reset_lw: got %08h lat=%0d required 12340000 %0d", rd, lat, RD_LAT);
        end
    endtask

    task automatic test_top_word();
        logic [31:0] rd; logic er; int lat;
        xact(1'b1, 9'h1FC, 32'hA5C3_5A3C, 3'b010, rd, er, lat);
        xact(1'b0, 9'h1FC, 32'h0, 3'b010, rd, er, lat);
        checks++;
        if (rd !== 32'hA5C35A3C) begin
            errors++; $display("FAIL top_lw: got %08h required a5c35a3c", rd);
        end
        xact(1'b0, 9'h1FF, 32'h0, 3'b000, rd, er, lat);
        checks++;
        if (rd !== 32'hFFFFFFA5) begin
            errors++; $display("FAIL top_lb: got %08h required ffffffa5", rd);
        end
        xact(1'b0, 9'h010, 32'h0, 3'b010, rd, er, lat);
        checks++;
        if (rd !== 32'h80ADBEEF) begin
            errors++; $display("FAIL top_no_alias: got %08h required 80adbeef", rd);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_word();
        test_byte_half();
        test_half_store();
        test_errors();
        test_backpressure();
        test_reset_wait();
        test_top_word();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
